// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel, 12-bit A2D converter: decodes a 16-bit
// channel command on MOSI and returns the previous conversion on MISO.
module a2d_spi_resp #(
    parameter logic [11:0] INC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        wr_en,
    input  logic [2:0]  wr_chnnl,
    input  logic [11:0] wr_data,
    output logic        cmd_vld,
    output logic [15:0] cmd,
    output logic [11:0] conv
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        WAIT_HI = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  ss_pipe_q, ss_pipe_d;
    logic [2:0]  sclk_pipe_q, sclk_pipe_d;
    logic [2:0]  mosi_pipe_q, mosi_pipe_d;
    logic [1:0]  start_cnt_q, start_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic        ovr_q, ovr_d;
    logic        miso_q, miso_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic [15:0] cmd_q, cmd_d;
    logic [11:0] conv_q, conv_d;
    logic [11:0] regs_q [8];
    logic [11:0] regs_d [8];

    logic        ss_fall_s, ss_rise_s;
    logic        sclk_fall_s, sclk_rise_s;
    logic        mosi_sync_s;
    logic        start_done_s;
    logic        acc_s;
    logic [2:0]  acc_ch_s;

    // Synchronizer shift chains, edge detection and post-reset settle counter
    always_comb begin
        ss_pipe_d    = {ss_pipe_q[1:0], SS_n};
        sclk_pipe_d  = {sclk_pipe_q[1:0], SCLK};
        mosi_pipe_d  = {mosi_pipe_q[1:0], MOSI};
        ss_fall_s    = ss_pipe_q[2] & ~ss_pipe_q[1];
        ss_rise_s    = ~ss_pipe_q[2] & ss_pipe_q[1];
        sclk_fall_s  = sclk_pipe_q[2] & ~sclk_pipe_q[1];
        sclk_rise_s  = ~sclk_pipe_q[2] & sclk_pipe_q[1];
        mosi_sync_s  = mosi_pipe_q[1];
        start_done_s = (start_cnt_q == 2'd3);
        start_cnt_d  = start_done_s ? start_cnt_q : (start_cnt_q + 2'd1);
    end

    // Transaction state machine, shifters and capture at SS_n release
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        ovr_d      = ovr_q;
        cmd_d      = cmd_q;
        conv_d     = conv_q;
        cmd_vld_d  = 1'b0;
        acc_s      = 1'b0;
        acc_ch_s   = rx_shift_q[13:11];

        case (state_q)
            IDLE: begin
                // A fall seen before the synchronizers have settled is the
                // reset value meeting an SS_n that was already low.
                if (ss_fall_s) begin
                    if (start_done_s) begin
                        state_d    = ACTIVE;
                        tx_shift_d = {4'h0, conv_q};
                        bit_cnt_d  = 5'd0;
                        rx_shift_d = 16'h0000;
                        ovr_d      = 1'b0;
                    end else begin
                        state_d = WAIT_HI;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    state_d = IDLE;
                    if ((bit_cnt_q == 5'd16) && !ovr_q) begin
                        acc_s     = 1'b1;
                        cmd_vld_d = 1'b1;
                        cmd_d     = rx_shift_q;
                        conv_d    = regs_q[rx_shift_q[13:11]];
                    end else begin
                        acc_s = 1'b0;
                    end
                end else if (sclk_rise_s) begin
                    if (bit_cnt_q == 5'd16) begin
                        ovr_d = 1'b1;
                    end else begin
                        rx_shift_d = {rx_shift_q[14:0], mosi_sync_s};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q != 5'd0) begin
                        tx_shift_d = {tx_shift_q[14:0], 1'b0};
                    end else begin
                        tx_shift_d = tx_shift_q;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            WAIT_HI: begin
                if (ss_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        miso_d = (state_d == ACTIVE) ? tx_shift_d[15] : 1'b0;
    end

    // Channel register file: side-port write overrides the auto-increment
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = (wr_en && (wr_chnnl == 3'(i))) ? wr_data :
                        ((acc_s && (acc_ch_s == 3'(i))) ? (regs_q[i] + INC) : regs_q[i]);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_pipe_q   <= 3'b111;
            sclk_pipe_q <= 3'b111;
            mosi_pipe_q <= 3'b000;
            start_cnt_q <= 2'd0;
            bit_cnt_q   <= 5'd0;
            rx_shift_q  <= 16'h0000;
            tx_shift_q  <= 16'h0000;
            ovr_q       <= 1'b0;
            miso_q      <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_q       <= 16'h0000;
            conv_q      <= 12'h000;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 12'h111 * 12'(i);
            end
        end else begin
            state_q     <= state_d;
            ss_pipe_q   <= ss_pipe_d;
            sclk_pipe_q <= sclk_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            start_cnt_q <= start_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            ovr_q       <= ovr_d;
            miso_q      <= miso_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_q       <= cmd_d;
            conv_q      <= conv_d;
            regs_q      <= regs_d;
        end
    end

    assign MISO    = miso_q;
    assign cmd_vld = cmd_vld_q;
    assign cmd     = cmd_q;
    assign conv    = conv_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: SPI master driver, channel model and
// a queue of expected MISO words checked as each transaction completes.
module tb_a2d_spi_resp;

    localparam logic [11:0] INC = 12'h001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        wr_en;
    logic [2:0]  wr_chnnl;
    logic [11:0] wr_data;
    logic        cmd_vld;
    logic [15:0] cmd;
    logic [11:0] conv;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] m_regs [8];
    logic [11:0] m_conv;
    logic [15:0] m_cmd;
    logic [15:0] exp_q [$];

    logic [15:0] o_miso;
    int          o_vld_cnt;
    int          o_vld_pos;
    logic [15:0] o_cmd;
    logic [11:0] o_conv;

    a2d_spi_resp #(.INC(INC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .wr_en    (wr_en),
        .wr_chnnl (wr_chnnl),
        .wr_data  (wr_data),
        .cmd_vld  (cmd_vld),
        .cmd      (cmd),
        .conv     (conv)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 12'h111 * 12'(i);
        m_conv = 12'h000;
        m_cmd  = 16'h0000;
    endtask

    task automatic model_accept(input logic [15:0] c);
        m_cmd            = c;
        m_conv           = m_regs[c[13:11]];
        m_regs[c[13:11]] = m_regs[c[13:11]] + INC;
    endtask

    task automatic write_reg(input logic [2:0] ch, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_chnnl = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_regs[ch] = d;
    endtask

    // One SPI transaction; optionally fires wr_en in the capture cycle.
    task automatic xfer(input logic [15:0] c, input int nclk, input int half,
                        input logic do_wr, input logic [2:0] wch, input logic [11:0] wdat);
        o_miso = 16'h0000; o_vld_cnt = 0; o_vld_pos = 0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? c[15-i] : 1'b0;
            repeat (half) @(negedge clk);
            if (i < 16) o_miso[15-i] = MISO;
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
        end
        SS_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (do_wr && (k == 2)) begin
                wr_en = 1'b1; wr_chnnl = wch; wr_data = wdat;
            end else begin
                wr_en = 1'b0;
            end
            if (cmd_vld) begin
                o_vld_cnt++; o_vld_pos = k; o_cmd = cmd; o_conv = conv;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if ((MISO !== 1'b0) || (cmd_vld !== 1'b0) || (cmd !== 16'h0000) || (conv !== 12'h000)) begin
            n_fail++;
            $display("FAIL reset_state: MISO=%b cmd_vld=%b cmd=%h conv=%h, want 0/0/0000/000",
                     MISO, cmd_vld, cmd, conv);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp;
        exp_q.push_back({4'h0, m_conv});
        xfer(16'h1000, 16, 8, 1'b0, 3'd0, 12'h000);
        model_accept(16'h1000);
        exp = exp_q.pop_front();
        n_tests++;
        if ((o_miso !== exp) || (o_miso !== 16'h0000)) begin
            n_fail++; $display("FAIL basic_first_miso: got %h want 0000", o_miso);
        end
        n_tests++;
        if ((o_vld_cnt !== 1) || (o_vld_pos !== 3)) begin
            n_fail++; $display("FAIL basic_vld: count=%0d pos=%0d want 1 at 3", o_vld_cnt, o_vld_pos);
        end
        n_tests++;
        if ((o_cmd !== 16'h1000) || (o_conv !== 12'h222)) begin
            n_fail++; $display("FAIL basic_capture: cmd=%h conv=%h want 1000/222", o_cmd, o_conv);
        end
        exp_q.push_back({4'h0, m_conv});
        xfer(16'h0000, 16, 8, 1'b0, 3'd0, 12'h000);
        model_accept(16'h0000);
        exp = exp_q.pop_front();
        n_tests++;
        if ((o_miso !== exp) || (o_miso !== 16'h0222) || (o_conv !== 12'h000)) begin
            n_fail++; $display("FAIL basic_second: miso=%h conv=%h want 0222/000", o_miso, o_conv);
        end
    endtask

    task automatic test_write_all();
        logic [15:0] exp;
        logic [15:0] c;
        logic [11:0] d;
        for (int ch = 0; ch < 9; ch++) begin
            if (ch < 8) begin
                d = 12'hA5C ^ (12'h111 * 12'(ch));
                write_reg(3'(ch), d);
                c = {2'(ch), 3'(ch), 11'h5A5 ^ 11'(ch)};
            end else begin
                c = 16'h0000;
            end
            exp_q.push_back({4'h0, m_conv});
            xfer(c, 16, 7, 1'b0, 3'd0, 12'h000);
            model_accept(c);
            exp = exp_q.pop_front();
            n_tests++;
            if (o_miso !== exp) begin
                n_fail++; $display("FAIL write_all_miso ch%0d: got %h want %h", ch, o_miso, exp);
            end
            n_tests++;
            if ((o_vld_cnt !== 1) || (o_cmd !== m_cmd) || (o_conv !== m_conv)) begin
                n_fail++;
                $display("FAIL write_all_capture ch%0d: vld=%0d cmd=%h conv=%h want 1/%h/%h",
                         ch, o_vld_cnt, o_cmd, o_conv, m_cmd, m_conv);
            end
        end
    endtask

    task automatic test_inc_wrap();
        logic [15:0] exp;
        logic [11:0] want_conv [4];
        want_conv[0] = 12'hFFF; want_conv[1] = 12'h000;
        want_conv[2] = 12'h001; want_conv[3] = 12'h5C3;
        write_reg(3'd7, 12'hFFF);
        for (int t = 0; t < 4; t++) begin
            exp_q.push_back({4'h0, m_conv});
            xfer(16'h3800, 16, 6, (t == 2), 3'd7, 12'h5C3);
            model_accept(16'h3800);
            if (t == 2) m_regs[7] = 12'h5C3;
            exp = exp_q.pop_front();
            n_tests++;
            if ((o_miso !== exp) || (o_vld_cnt !== 1) || (o_conv !== want_conv[t])) begin
                n_fail++;
                $display("FAIL inc_wrap step%0d: miso=%h conv=%h vld=%0d want %h/%h/1",
                         t, o_miso, o_conv, o_vld_cnt, exp, want_conv[t]);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] exp;
        int nclks [2];
        nclks[0] = 10; nclks[1] = 17;
        for (int t = 0; t < 2; t++) begin
            xfer(16'h2800, nclks[t], 6, 1'b0, 3'd0, 12'h000);
            n_tests++;
            if ((o_vld_cnt !== 0) || (cmd !== m_cmd) || (conv !== m_conv)) begin
                n_fail++;
                $display("FAIL abort_%0dclk: vld=%0d cmd=%h conv=%h want 0/%h/%h",
                         nclks[t], o_vld_cnt, cmd, conv, m_cmd, m_conv);
            end
            exp_q.push_back({4'h0, m_conv});
            xfer(16'h2000, 16, 6, 1'b0, 3'd0, 12'h000);
            model_accept(16'h2000);
            exp = exp_q.pop_front();
            n_tests++;
            if ((o_miso !== exp) || (o_vld_cnt !== 1) || (o_conv !== m_conv)) begin
                n_fail++;
                $display("FAIL abort_recover_%0d: miso=%h conv=%h vld=%0d want %h/%h/1",
                         nclks[t], o_miso, o_conv, o_vld_cnt, exp, m_conv);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        logic        miso_seen;
        int          vld_seen;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; repeat (6) @(negedge clk);
            SCLK = 1'b1; repeat (6) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ((MISO !== 1'b0) || (cmd_vld !== 1'b0) || (cmd !== 16'h0000) || (conv !== 12'h000)) begin
            n_fail++;
            $display("FAIL reset_mid_clear: MISO=%b vld=%b cmd=%h conv=%h want 0/0/0000/000",
                     MISO, cmd_vld, cmd, conv);
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        miso_seen = 1'b0; vld_seen = 0;
        for (int i = 0; i < 16; i++) begin
            SCLK = 1'b0; MOSI = 1'b1;
            repeat (6) @(negedge clk);
            miso_seen = miso_seen | MISO;
            SCLK = 1'b1;
            repeat (6) @(negedge clk);
        end
        SS_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cmd_vld) vld_seen++;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if ((miso_seen !== 1'b0) || (vld_seen !== 0) || (cmd !== 16'h0000) || (conv !== 12'h000)) begin
            n_fail++;
            $display("FAIL reset_mid_wait_hi: miso_seen=%b vld=%0d cmd=%h conv=%h want 0/0/0000/000",
                     miso_seen, vld_seen, cmd, conv);
        end
        exp_q.push_back({4'h0, m_conv});
        xfer(16'h1800, 16, 6, 1'b0, 3'd0, 12'h000);
        model_accept(16'h1800);
        exp = exp_q.pop_front();
        n_tests++;
        if ((o_miso !== exp) || (o_vld_cnt !== 1) || (o_conv !== 12'h333)) begin
            n_fail++;
            $display("FAIL reset_mid_next: miso=%h conv=%h vld=%0d want %h/333/1",
                     o_miso, o_conv, o_vld_cnt, exp);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        logic [15:0] c;
        for (int t = 0; t < 100; t++) begin
            c = {2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 11'($urandom_range(2047, 0))};
            exp_q.push_back({4'h0, m_conv});
            xfer(c, 16, 6, 1'b0, 3'd0, 12'h000);
            model_accept(c);
            exp = exp_q.pop_front();
            n_tests++;
            if ((o_miso !== exp) || (o_vld_cnt !== 1) || (o_vld_pos !== 3) ||
                (o_cmd !== m_cmd) || (o_conv !== m_conv)) begin
                n_fail++;
                $display("FAIL random_%0d: miso=%h cmd=%h conv=%h vld=%0d@%0d want %h/%h/%h/1@3",
                         t, o_miso, o_cmd, o_conv, o_vld_cnt, o_vld_pos, exp, m_cmd, m_conv);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wr_en = 1'b0; wr_chnnl = 3'd0; wr_data = 12'h000;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        test_reset();
        test_basic();
        test_write_all();
        test_inc_wrap();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
